// File: rtl/uart_dbg_cmd_decoder.sv
// Byte-serial debug command decoder: parses 'W'/'R' packets from the UART,
// runs one bus transfer per packet and returns ACK/NAK plus read data.
module uart_dbg_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_err,
    input  logic        tx_busy,
    input  logic        tx_sent,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        bus_req,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        busy
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam int unsigned TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS,
        SEND,
        WAIT_SENT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       byte_cnt;
    logic [TMR_W-1:0] timer;
    // Response bytes are left-aligned; the head byte always sits in [39:32].
    logic [39:0]      resp_q;
    logic [2:0]       resp_cnt;

    logic is_cmd;
    logic last_byte;
    logic timeout;
    logic bus_done;

    assign is_cmd    = (rx_byte == OP_WRITE) || (rx_byte == OP_READ);
    assign last_byte = (byte_cnt == 2'd3);
    assign timeout   = (timer == TMR_LAST);
    assign bus_done  = bus_req && bus_ack;
    assign tx_data   = resp_q[39:32];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, and the async reset
    // appears in the sensitivity list so outputs clear without a clock.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_nxt = is_cmd ? GET_ADDR : SEND;
                end
            end
            GET_ADDR: begin
                if (rx_err) begin
                    state_nxt = SEND;
                end else if (rx_valid) begin
                    if (last_byte) begin
                        state_nxt = bus_wen ? GET_DATA : BUS;
                    end
                end else if (timeout) begin
                    state_nxt = SEND;
                end
            end
            GET_DATA: begin
                if (rx_err) begin
                    state_nxt = SEND;
                end else if (rx_valid) begin
                    if (last_byte) begin
                        state_nxt = BUS;
                    end
                end else if (timeout) begin
                    state_nxt = SEND;
                end
            end
            BUS: begin
                if (bus_done) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    state_nxt = WAIT_SENT;
                end
            end
            WAIT_SENT: begin
                if (tx_sent) begin
                    state_nxt = (resp_cnt > 3'd1) ? SEND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        tx_start = (state == SEND) && !tx_busy;
    end

    // Packet assembly, bus handshake and response queue.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_req   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            byte_cnt  <= '0;
            timer     <= '0;
            resp_q    <= '0;
            resp_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (is_cmd) begin
                            bus_wen  <= (rx_byte == OP_WRITE);
                            byte_cnt <= '0;
                            timer    <= '0;
                        end else begin
                            resp_q   <= {NAK_BYTE, 32'h0};
                            resp_cnt <= 3'd1;
                        end
                    end
                end
                GET_ADDR, GET_DATA: begin
                    if (rx_err) begin
                        resp_q   <= {NAK_BYTE, 32'h0};
                        resp_cnt <= 3'd1;
                    end else if (rx_valid) begin
                        if (state == GET_ADDR) begin
                            bus_addr <= {bus_addr[23:0], rx_byte};
                        end else begin
                            bus_wdata <= {bus_wdata[23:0], rx_byte};
                        end
                        // Wraps from 3 back to 0, ready for the next field.
                        byte_cnt <= byte_cnt + 2'd1;
                        timer    <= '0;
                    end else if (timeout) begin
                        resp_q   <= {NAK_BYTE, 32'h0};
                        resp_cnt <= 3'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        bus_req <= 1'b0;
                        if (bus_err) begin
                            resp_q   <= {NAK_BYTE, 32'h0};
                            resp_cnt <= 3'd1;
                        end else if (bus_wen) begin
                            resp_q   <= {ACK_BYTE, 32'h0};
                            resp_cnt <= 3'd1;
                        end else begin
                            resp_q   <= {ACK_BYTE, bus_rdata};
                            resp_cnt <= 3'd5;
                        end
                    end else begin
                        bus_req <= 1'b1;
                    end
                end
                WAIT_SENT: begin
                    if (tx_sent) begin
                        resp_q   <= {resp_q[31:0], 8'h00};
                        resp_cnt <= resp_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_dbg_cmd_decoder.sv
// Self-checking bench: a fixed vector table, hand-written abort/reset sequences
// and random packets, all scored against a packet-level reference model.
module tb_uart_dbg_cmd_decoder;

    localparam int TIMEOUT = 50;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_err;
    logic        tx_busy;
    logic        tx_sent;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        bus_req;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;
    logic        busy;

    always #5 clk = ~clk;

    uart_dbg_cmd_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .ACK_BYTE      (ACK),
        .NAK_BYTE      (NAK)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .tx_busy  (tx_busy),
        .tx_sent  (tx_sent),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .bus_req  (bus_req),
        .bus_wen  (bus_wen),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .bus_err  (bus_err),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Observed traffic and responder configuration.
    logic [7:0]  tx_log[$];
    logic        bus_log_wen[$];
    logic [31:0] bus_log_addr[$];
    logic [31:0] bus_log_wdata[$];
    int          sent_cnt = 0;
    int          start_while_busy = 0;
    logic [31:0] cfg_rdata = 32'h0;
    logic        cfg_err = 1'b0;

    // Expected results for the packet in flight.
    logic [7:0]  pkt_q[$];
    logic        exp_bus;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    int          exp_ntx;
    logic [39:0] exp_tx;

    // UART transmitter: busy for a few cycles per byte, then a sent pulse,
    // sometimes staying busy a little longer.
    logic [7:0] uart_b;
    int         uart_tail;
    initial begin
        tx_busy = 1'b0;
        tx_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                uart_b = tx_data;
                tx_log.push_back(uart_b);
                uart_tail = $urandom_range(0, 2);
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 check("tx_data_stable", 64'(tx_data), 64'(uart_b));
                tx_sent = 1'b1;
                tx_busy = (uart_tail != 0);
                sent_cnt++;
                @(posedge clk);
                #1 tx_sent = 1'b0;
                repeat (uart_tail) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && tx_busy === 1'b1) start_while_busy++;
        end
    end

    // Bus slave: acknowledges each request after 0..3 cycles.
    int bus_lat;
    initial begin
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                bus_lat = $urandom_range(0, 3);
                repeat (bus_lat) @(negedge clk);
                bus_log_wen.push_back(bus_wen);
                bus_log_addr.push_back(bus_addr);
                bus_log_wdata.push_back(bus_wdata);
                bus_ack   = 1'b1;
                bus_rdata = cfg_rdata;
                bus_err   = cfg_err;
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_err   = 1'b0;
                bus_rdata = 32'h0;
                check("bus_req_drop", 64'(bus_req), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1 rx_byte = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        rx_byte = 8'h00;
        repeat (gap) @(posedge clk);
    endtask

    task automatic pulse_err(input logic with_valid, input logic [7:0] b);
        @(posedge clk);
        #1 rx_err = 1'b1;
        rx_valid = with_valid;
        rx_byte  = b;
        @(posedge clk);
        #1 rx_err = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        bus_log_wen.delete();
        bus_log_addr.delete();
        bus_log_wdata.delete();
    endtask

    task automatic send_pkt(input int gap);
        foreach (pkt_q[i]) send_byte(pkt_q[i], gap);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        #1;
        while (busy === 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle"}, 64'(n < limit), 64'd1);
    endtask

    task automatic compare(input string name);
        check({name, "_nbus"}, 64'(bus_log_wen.size()), 64'(exp_bus));
        if (exp_bus && bus_log_wen.size() > 0) begin
            check({name, "_wen"}, 64'(bus_log_wen[0]), 64'(exp_wen));
            check({name, "_addr"}, 64'(bus_log_addr[0]), 64'(exp_addr));
            if (exp_wen) check({name, "_wdata"}, 64'(bus_log_wdata[0]), 64'(exp_wdata));
        end
        check({name, "_ntx"}, 64'(tx_log.size()), 64'(exp_ntx));
        for (int i = 0; i < exp_ntx && i < tx_log.size(); i++) begin
            check($sformatf("%s_tx%0d", name, i), 64'(tx_log[i]), 64'(exp_tx[39-8*i -: 8]));
        end
    endtask

    task automatic build_pkt(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        pkt_q.delete();
        pkt_q.push_back(op);
        if (op == 8'h57 || op == 8'h52) begin
            for (int i = 3; i >= 0; i--) pkt_q.push_back(addr[8*i +: 8]);
        end
        if (op == 8'h57) begin
            for (int i = 3; i >= 0; i--) pkt_q.push_back(wdata[8*i +: 8]);
        end
    endtask

    // Packet-level reference: what the host should see for a complete packet.
    task automatic ref_model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic err);
        exp_addr  = addr;
        exp_wdata = wdata;
        exp_wen   = (op == 8'h57);
        exp_bus   = (op == 8'h57) || (op == 8'h52);
        if (!exp_bus || err) begin
            exp_ntx = 1;
            exp_tx  = {NAK, 32'h0};
        end else if (exp_wen) begin
            exp_ntx = 1;
            exp_tx  = {ACK, 32'h0};
        end else begin
            exp_ntx = 5;
            exp_tx  = {ACK, rdata};
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        e_bus;
        logic        e_wen;
        int          e_ntx;
        logic [39:0] e_tx;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] op;
        logic [31:0] a, d, r;
        logic e;
        int sel;

        vecs[0] = '{8'h57, 32'h12345678, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1, 1, 40'h06_0000_0000};
        vecs[1] = '{8'h52, 32'h00001000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 5, 40'h06_CAFE_F00D};
        vecs[2] = '{8'h41, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 40'h15_0000_0000};
        vecs[3] = '{8'h57, 32'h00000004, 32'h11223344, 32'h0, 1'b0, 1'b1, 1'b1, 1, 40'h06_0000_0000};
        vecs[4] = '{8'h52, 32'h0000ABCD, 32'h0, 32'h55555555, 1'b1, 1'b1, 1'b0, 1, 40'h15_0000_0000};
        vecs[5] = '{8'h57, 32'hFFFFFFFC, 32'h00000001, 32'h0, 1'b1, 1'b1, 1'b1, 1, 40'h15_0000_0000};
        vecs[6] = '{8'h52, 32'hFFFFFFFF, 32'h0, 32'h00000000, 1'b0, 1'b1, 1'b0, 5, 40'h06_0000_0000};
        vecs[7] = '{8'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 40'h15_0000_0000};

        n_rst    = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        #1;
        check("reset_ctrl", 64'({tx_start, tx_data, bus_req, bus_wen, busy}), 64'd0);
        check("reset_addr_wdata", {bus_addr, bus_wdata}, 64'd0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        check("post_reset_busy", 64'(busy), 64'd0);

        // A framing error while idle must be ignored.
        pulse_err(1'b0, 8'h00);
        #1 check("idle_rx_err_ignored", 64'(busy), 64'd0);

        foreach (vecs[v]) begin
            cfg_rdata = vecs[v].rdata;
            cfg_err   = vecs[v].err;
            exp_bus   = vecs[v].e_bus;
            exp_wen   = vecs[v].e_wen;
            exp_addr  = vecs[v].addr;
            exp_wdata = vecs[v].wdata;
            exp_ntx   = vecs[v].e_ntx;
            exp_tx    = vecs[v].e_tx;
            build_pkt(vecs[v].op, vecs[v].addr, vecs[v].wdata);
            clear_logs();
            send_pkt(v % 3);
            wait_idle($sformatf("vec%0d", v), 4000);
            compare($sformatf("vec%0d", v));
        end

        // Inter-byte timeout: packet stalls after two address bytes.
        cfg_err = 1'b0;
        clear_logs();
        pkt_q.delete();
        pkt_q.push_back(8'h57);
        pkt_q.push_back(8'h12);
        pkt_q.push_back(8'h34);
        send_pkt(0);
        repeat (40) @(posedge clk);
        #1 check("timeout_not_early", 64'(busy), 64'd1);
        wait_idle("timeout", 4000);
        ref_model(8'h00, 32'h0, 32'h0, 32'h0, 1'b0);
        compare("timeout");

        // Long but legal gaps between bytes still complete.
        clear_logs();
        build_pkt(8'h57, 32'hA5A5_0001, 32'h0BAD_F00D);
        ref_model(8'h57, 32'hA5A5_0001, 32'h0BAD_F00D, 32'h0, 1'b0);
        send_pkt(45);
        wait_idle("long_gap", 4000);
        compare("long_gap");

        // Framing error after two address bytes.
        clear_logs();
        pkt_q.delete();
        pkt_q.push_back(8'h57);
        pkt_q.push_back(8'h12);
        pkt_q.push_back(8'h34);
        send_pkt(0);
        pulse_err(1'b0, 8'h00);
        wait_idle("rx_err", 4000);
        ref_model(8'h00, 32'h0, 32'h0, 32'h0, 1'b0);
        compare("rx_err");

        // rx_err and rx_valid together: the error wins, so NAK follows well before any timeout.
        clear_logs();
        pkt_q.delete();
        pkt_q.push_back(8'h52);
        pkt_q.push_back(8'h00);
        send_pkt(0);
        pulse_err(1'b1, 8'h10);
        wait_idle("err_and_valid", 30);
        compare("err_and_valid");

        // Bytes arriving during the bus transfer / response are dropped.
        clear_logs();
        cfg_rdata = 32'h0;
        build_pkt(8'h57, 32'h0000_0100, 32'h0000_0200);
        ref_model(8'h57, 32'h0000_0100, 32'h0000_0200, 32'h0, 1'b0);
        send_pkt(0);
        send_byte(8'h52, 0);
        send_byte(8'h41, 0);
        wait_idle("drop", 4000);
        compare("drop");
        repeat (10) @(posedge clk);
        #1 check("drop_stays_idle", 64'(busy), 64'd0);

        // Reset after two of five read-response bytes have gone out.
        clear_logs();
        cfg_rdata = 32'h1122_3344;
        build_pkt(8'h52, 32'h0000_0020, 32'h0);
        sent_cnt = 0;
        send_pkt(0);
        begin
            int n;
            n = 0;
            while (sent_cnt < 2 && n < 4000) begin
                @(posedge clk);
                #2;
                n++;
            end
            check("mid_reset_reached", 64'(n < 4000), 64'd1);
        end
        n_rst = 1'b0;
        #1;
        check("mid_reset_ctrl", 64'({tx_start, tx_data, bus_req, bus_wen, busy}), 64'd0);
        check("mid_reset_addr_wdata", {bus_addr, bus_wdata}, 64'd0);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        exp_bus = 1'b1;
        exp_wen = 1'b0;
        exp_addr = 32'h0000_0020;
        exp_ntx = 2;
        exp_tx  = {ACK, 8'h11, 24'h0};
        compare("mid_reset");
        check("mid_reset_idle", 64'(busy), 64'd0);

        // Next packet after the reset is handled normally.
        clear_logs();
        cfg_rdata = 32'h0;
        build_pkt(8'h57, 32'hCAFE_0000, 32'h1234_5678);
        ref_model(8'h57, 32'hCAFE_0000, 32'h1234_5678, 32'h0, 1'b0);
        send_pkt(1);
        wait_idle("post_reset_write", 4000);
        compare("post_reset_write");

        // Random packets against the reference model.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                op = 8'h57;
            end else if (sel < 8) begin
                op = 8'h52;
            end else begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h57 || op == 8'h52) op = op ^ 8'h01;
            end
            a = $urandom;
            d = $urandom;
            r = $urandom;
            e = ($urandom_range(0, 3) == 0);
            cfg_rdata = r;
            cfg_err   = e;
            build_pkt(op, a, d);
            ref_model(op, a, d, r, e);
            clear_logs();
            send_pkt($urandom_range(0, 5));
            wait_idle($sformatf("rnd%0d", k), 4000);
            compare($sformatf("rnd%0d", k));
        end

        repeat (10) @(posedge clk);
        check("tx_start_vs_busy", 64'(start_while_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
